// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
package uart_rx_pkg;

   localparam int DATA_W        = 8;
   localparam int SAMPLE_OFS    = 2;
   localparam int STOP_DONE_OFS = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      OUT    = 3'd5
   } state_e;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: drives counter/sampler/checker enables and
// flags a clean frame with a one-cycle data_valid pulse.
module uart_rx_fsm #(
   parameter int DATA_W = uart_rx_pkg::DATA_W,
   parameter int PRE_W  = 6,
   parameter int BIT_W  = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RX_IN,
   input  logic             PAR_EN,
   input  logic [PRE_W-1:0] Prescale,
   input  logic [PRE_W-1:0] edge_cnt,
   input  logic [BIT_W-1:0] bit_cnt,
   input  logic             strt_glitch,
   input  logic             par_err,
   input  logic             stp_err,
   output logic             cnt_en,
   output logic             dat_samp_en,
   output logic             strt_chk_en,
   output logic             par_chk_en,
   output logic             stp_chk_en,
   output logic             deser_en,
   output logic             data_valid
);
   import uart_rx_pkg::*;

   state_e           state_q, state_d;
   logic             par_en_q, par_en_d;
   logic [PRE_W-1:0] prescale_q, prescale_d;
   logic             cnt_en_q, cnt_en_d;
   logic             dat_samp_en_q, dat_samp_en_d;
   logic             strt_chk_en_q, strt_chk_en_d;
   logic             par_chk_en_q, par_chk_en_d;
   logic             stp_chk_en_q, stp_chk_en_d;
   logic             deser_en_q, deser_en_d;
   logic             data_valid_q, data_valid_d;

   logic             last_edge, deser_pt, stop_done, frame_err;

   // Timing points use the Prescale captured at frame start, not the live port.
   assign last_edge = (edge_cnt == prescale_q - PRE_W'(1));
   assign deser_pt  = (edge_cnt == (prescale_q >> 1) + PRE_W'(SAMPLE_OFS));
   assign stop_done = (edge_cnt == (prescale_q >> 1) + PRE_W'(STOP_DONE_OFS));
   assign frame_err = stp_err | (par_en_q & par_err);

   always_comb begin
      state_d    = state_q;
      par_en_d   = par_en_q;
      prescale_d = prescale_q;
      deser_en_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!RX_IN) begin
               state_d    = START;
               par_en_d   = PAR_EN;
               prescale_d = Prescale;
            end
         end
         START: begin
            if (last_edge) state_d = strt_glitch ? IDLE : DATA;
         end
         DATA: begin
            deser_en_d = deser_pt;
            if (last_edge && (bit_cnt == BIT_W'(DATA_W))) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (last_edge) state_d = STOP;
         end
         STOP: begin
            if (stop_done) state_d = frame_err ? IDLE : OUT;
         end
         OUT: begin
            if (!RX_IN) begin
               state_d    = START;
               par_en_d   = PAR_EN;
               prescale_d = Prescale;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs follow the next state so they appear registered with it.
      cnt_en_d      = (state_d == START) || (state_d == DATA) ||
                      (state_d == PARITY) || (state_d == STOP);
      dat_samp_en_d = cnt_en_d;
      strt_chk_en_d = (state_d == START);
      par_chk_en_d  = (state_d == PARITY);
      stp_chk_en_d  = (state_d == STOP);
      data_valid_d  = (state_d == OUT);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q       <= IDLE;
         par_en_q      <= 1'b0;
         prescale_q    <= '0;
         cnt_en_q      <= 1'b0;
         dat_samp_en_q <= 1'b0;
         strt_chk_en_q <= 1'b0;
         par_chk_en_q  <= 1'b0;
         stp_chk_en_q  <= 1'b0;
         deser_en_q    <= 1'b0;
         data_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         par_en_q      <= par_en_d;
         prescale_q    <= prescale_d;
         cnt_en_q      <= cnt_en_d;
         dat_samp_en_q <= dat_samp_en_d;
         strt_chk_en_q <= strt_chk_en_d;
         par_chk_en_q  <= par_chk_en_d;
         stp_chk_en_q  <= stp_chk_en_d;
         deser_en_q    <= deser_en_d;
         data_valid_q  <= data_valid_d;
      end
   end

   assign cnt_en      = cnt_en_q;
   assign dat_samp_en = dat_samp_en_q;
   assign strt_chk_en = strt_chk_en_q;
   assign par_chk_en  = par_chk_en_q;
   assign stp_chk_en  = stp_chk_en_q;
   assign deser_en    = deser_en_q;
   assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a behavioural edge/bit counter and a
// per-frame scoreboard checked whenever cnt_en falls.
module tb_uart_rx_fsm;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic [5:0] edge_cnt = '0;
   logic [3:0] bit_cnt = '0;
   logic       strt_glitch = 1'b0;
   logic       par_err = 1'b0;
   logic       stp_err = 1'b0;
   logic       cnt_en, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;

   uart_rx_fsm #(.DATA_W(8), .PRE_W(6), .BIT_W(4)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
      .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
      .par_err(par_err), .stp_err(stp_err), .cnt_en(cnt_en), .dat_samp_en(dat_samp_en),
      .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
      .deser_en(deser_en), .data_valid(data_valid)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int end_cyc;
      int valid;
      int deser;
      int par;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         cur_p = 8;
   logic [5:0] m_edge = '0;
   logic [3:0] m_bit = '0;
   logic       prev_en = 1'b0;
   int         deser_seen = 0, valid_seen = 0, valid_cyc = -1, par_seen = 0;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic line_val(input logic [7:0] d, input bit pe, input bit sbit, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (b == 9) return pe ? ^d : sbit;
      if (b == 10 && pe) return sbit;
      return 1'b1;
   endfunction

   task automatic tick();
      logic en, rst_pre;
      exp_t e;
      en = cnt_en;
      rst_pre = RST;
      @(posedge CLK);
      #1;
      cyc++;
      if (!rst_pre || !en) begin
         m_edge = '0;
         m_bit  = '0;
      end else if (int'(m_edge) == cur_p - 1) begin
         m_edge = '0;
         m_bit  = m_bit + 4'd1;
      end else begin
         m_edge = m_edge + 6'd1;
      end
      edge_cnt = m_edge;
      bit_cnt  = m_bit;
      check("chk_mutex", 32'($onehot0({strt_chk_en, par_chk_en, stp_chk_en})), 1);
      if (deser_en) deser_seen++;
      if (data_valid) begin
         valid_seen++;
         valid_cyc = cyc;
      end
      if (par_chk_en) par_seen = 1;
      if (prev_en && !cnt_en) begin
         check("frame_queued", sb.size(), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("end_cycle", cyc, e.end_cyc);
            check("valid_count", valid_seen, e.valid);
            check("deser_count", deser_seen, e.deser);
            check("par_chk_seen", par_seen, e.par);
            if (e.valid != 0) check("valid_cycle", valid_cyc, e.end_cyc);
         end
         deser_seen = 0;
         valid_seen = 0;
         valid_cyc  = -1;
         par_seen   = 0;
      end
      prev_en = cnt_en;
   endtask

   task automatic run_frame(input logic [7:0] d, input int p, input bit pe, input bit perr,
                            input bit serr, input bit sbit, input bit b2b);
      int   s, len;
      exp_t e;
      Prescale = 6'(p);
      PAR_EN = pe;
      par_err = perr;
      stp_err = serr;
      strt_glitch = 1'b0;
      cur_p = p;
      s = cyc + 1;
      len = (pe ? 10 : 9) * p + p / 2 + 4;
      e.end_cyc = s + len;
      e.valid = (serr || (pe && perr)) ? 0 : 1;
      e.deser = 8;
      e.par = pe ? 1 : 0;
      sb.push_back(e);
      RX_IN = 1'b0;
      tick();
      check("start_en", 32'(cnt_en), 1);
      // Live configuration changes mid-frame must not affect this frame.
      Prescale = (p == 16) ? 6'd32 : 6'd16;
      PAR_EN = !pe;
      while (cyc < s + len) begin
         RX_IN = line_val(d, pe, sbit, (cyc - s) / p);
         tick();
      end
      RX_IN = b2b ? 1'b0 : 1'b1;
      par_err = 1'b0;
      stp_err = 1'b0;
   endtask

   initial begin
      int   s;
      exp_t e;

      repeat (3) tick();
      check("rst_cnt_en", 32'(cnt_en), 0);
      check("rst_dat_samp_en", 32'(dat_samp_en), 0);
      check("rst_strt_chk_en", 32'(strt_chk_en), 0);
      check("rst_par_chk_en", 32'(par_chk_en), 0);
      check("rst_stp_chk_en", 32'(stp_chk_en), 0);
      check("rst_deser_en", 32'(deser_en), 0);
      check("rst_data_valid", 32'(data_valid), 0);
      RST = 1'b1;
      repeat (3) tick();
      check("idle_cnt_en", 32'(cnt_en), 0);

      run_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      run_frame(8'h81, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      run_frame(8'hA3, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();

      // Start-bit glitch: line low for three clocks only.
      Prescale = 6'd8;
      PAR_EN = 1'b0;
      cur_p = 8;
      strt_glitch = 1'b1;
      s = cyc + 1;
      e.end_cyc = s + 8; e.valid = 0; e.deser = 0; e.par = 0;
      sb.push_back(e);
      RX_IN = 1'b0;
      repeat (3) tick();
      RX_IN = 1'b1;
      while (cyc < s + 8) tick();
      strt_glitch = 1'b0;
      repeat (3) tick();
      check("glitch_idle_cnt_en", 32'(cnt_en), 0);

      run_frame(8'h0F, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      run_frame(8'hF0, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();

      // Reset in the middle of data bit 4.
      Prescale = 6'd8;
      PAR_EN = 1'b0;
      cur_p = 8;
      s = cyc + 1;
      e.end_cyc = s + 33; e.valid = 0; e.deser = 3; e.par = 0;
      sb.push_back(e);
      RX_IN = 1'b0;
      tick();
      while (cyc < s + 32) begin
         RX_IN = line_val(8'h3C, 1'b0, 1'b1, (cyc - s) / 8);
         tick();
      end
      check("mid_bit_cnt", 32'(bit_cnt), 4);
      RST = 1'b0;
      RX_IN = 1'b1;
      tick();
      check("mid_rst_cnt_en", 32'(cnt_en), 0);
      check("mid_rst_dat_samp_en", 32'(dat_samp_en), 0);
      check("mid_rst_strt_chk_en", 32'(strt_chk_en), 0);
      check("mid_rst_par_chk_en", 32'(par_chk_en), 0);
      check("mid_rst_stp_chk_en", 32'(stp_chk_en), 0);
      check("mid_rst_deser_en", 32'(deser_en), 0);
      check("mid_rst_data_valid", 32'(data_valid), 0);
      RST = 1'b1;
      repeat (3) tick();
      run_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      run_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();

      // Line stuck low: stop error, then immediate rearm on the low level.
      run_frame(8'h00, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      e.end_cyc = cyc + 2; e.valid = 0; e.deser = 0; e.par = 0;
      sb.push_back(e);
      tick();
      check("rearm_cnt_en", 32'(cnt_en), 1);
      RST = 1'b0;
      RX_IN = 1'b1;
      tick();
      RST = 1'b1;
      repeat (4) tick();

      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
